// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets and reset values shared by the GPIO input port.
package gpio_pkg;
    localparam logic [1:0] GPIO_IN_DATA = 2'd0;
    localparam logic [1:0] GPIO_IN_EDGE = 2'd1;
    localparam logic [1:0] GPIO_IN_MASK = 2'd2;
    localparam logic [1:0] GPIO_IN_RSVD = 2'd3;
    localparam logic       PIN_RESET    = 1'b0;
endpackage

// File: rtl/gpio_input_port_debounce_bit.sv
// debounce_bit: two-flop synchroniser plus stable-count debouncer for one input pin.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic pin,
    output logic stable
);
    import gpio_pkg::*;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync   <= {2{PIN_RESET}};
            stable <= PIN_RESET;
            cnt    <= '0;
        end else begin
            sync <= {sync[0], pin};
            if (sync[1] == stable)
                cnt <= '0;
            else if (enable) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable <= sync[1];
                    cnt    <= '0;
                end else
                    cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/gpio_input_port.sv
// gpio_input_port: debounced switch inputs with sticky rising-edge flags, mask and level irq.
module gpio_input_port
    import gpio_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int IN_WIDTH        = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [IN_WIDTH-1:0]   pins_in,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  irq
);
    logic [IN_WIDTH-1:0]   stable, stable_q, edge_q, mask, rise, clr, sel;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  unused_wr;
    for (genvar i = 0; i < IN_WIDTH; i++) begin : g_bit
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(clk), .reset(reset), .enable(enable), .pin(pins_in[i]), .stable(stable[i])
        );
    end
    assign unused_wr = ^wr_data;
    assign rise = stable & ~stable_q;
    // Reads of EDGE clear only what was returned; new rises in the same cycle survive.
    assign clr = (rd_en && addr == GPIO_IN_EDGE ? edge_q : '0)
               | (wr_en && addr == GPIO_IN_EDGE ? wr_data[IN_WIDTH-1:0] : '0);
    assign sel = addr == GPIO_IN_DATA ? stable :
                 addr == GPIO_IN_EDGE ? edge_q :
                 addr == GPIO_IN_MASK ? mask : '0;
    always_comb begin
        rd_mux = '0;
        rd_mux[IN_WIDTH-1:0] = sel;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= '0;
            edge_q   <= '0;
            mask     <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            irq      <= 1'b0;
        end else begin
            stable_q <= stable;
            edge_q   <= (edge_q & ~clr) | rise;
            mask     <= wr_en && addr == GPIO_IN_MASK ? wr_data[IN_WIDTH-1:0] : mask;
            rd_data  <= rd_en ? rd_mux : rd_data;
            rd_valid <= rd_en;
            irq      <= |(edge_q & mask);
        end
    end
endmodule
